// File: rtl/r_cpl_fsm_if.sv
// R-channel to completion bridge: request push, AXI R, completion header/data streams.
interface r_cpl_fsm_if #(
  parameter int DATA_WIDTH = 256
);
  // read-context push side
  logic                  req_wren;
  logic [9:0]            req_tag;
  logic [9:0]            req_len_dw;
  logic [15:0]           req_requester_id;
  logic [6:0]            req_addr_lo;
  logic                  req_full;
  logic [15:0]           cfg_completer_id;
  // AXI R channel
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [9:0]            rid;
  logic                  rready;
  // completion streams
  logic                  cpl_hdr_valid;
  logic [95:0]           cpl_hdr;
  logic                  cpl_hdr_ready;
  logic                  cpl_data_valid;
  logic [DATA_WIDTH-1:0] cpl_data;
  logic                  cpl_data_last;
  logic                  cpl_data_ready;
  // error pulses
  logic                  err_ctx_ovf;
  logic                  err_rid;
  logic                  err_rlast;

  modport master (
    output req_wren, req_tag, req_len_dw, req_requester_id, req_addr_lo, cfg_completer_id,
    output rvalid, rdata, rresp, rlast, rid, cpl_hdr_ready, cpl_data_ready,
    input  req_full, rready, cpl_hdr_valid, cpl_hdr, cpl_data_valid, cpl_data, cpl_data_last,
    input  err_ctx_ovf, err_rid, err_rlast
  );

  modport slave (
    input  req_wren, req_tag, req_len_dw, req_requester_id, req_addr_lo, cfg_completer_id,
    input  rvalid, rdata, rresp, rlast, rid, cpl_hdr_ready, cpl_data_ready,
    output req_full, rready, cpl_hdr_valid, cpl_hdr, cpl_data_valid, cpl_data, cpl_data_last,
    output err_ctx_ovf, err_rid, err_rlast
  );
endinterface

// File: rtl/r_cpl_fsm.sv
// Turns AXI R beats into PCIe CplD/Cpl TLPs using an in-order read-context FIFO.
module r_cpl_fsm #(
  parameter int DATA_WIDTH     = 256,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  r_cpl_fsm_if.slave bus
);
  localparam int DPB = DATA_WIDTH / 32;
  localparam int PW  = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(REQ_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  typedef struct packed {
    logic [9:0]  tag;
    logic [9:0]  len;
    logic [15:0] reqid;
    logic [6:0]  addr;
  } ctx_t;

  ctx_t          ctx_mem_q [REQ_FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q;
  logic [95:0]   hdr_q;
  logic [2:0]    status_q;
  logic [10:0]   exp_q, beat_q;
  logic          ovf_q, err_rid_q, err_rlast_q;

  ctx_t        head;
  logic        full, empty, r_hs, last_beat, push, pop;
  logic [10:0] eff_len, exp_d;
  logic [2:0]  status_d;
  logic        sc_d;
  logic [31:0] dw0_d, dw1_d, dw2_d;

  assign head      = ctx_mem_q[rptr_q];
  assign full      = (cnt_q == CW'(REQ_FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign r_hs      = bus.rvalid && bus.rready;
  assign last_beat = (beat_q == exp_q - 11'd1);
  assign pop       = r_hs && last_beat && (state_q == DATA || state_q == DRAIN);
  // a full FIFO can still take a push when the head retires in the same cycle
  assign push      = bus.req_wren && (!full || pop);

  // header fields for the head context, captured when the first beat shows up
  assign eff_len = (head.len == 10'd0) ? 11'd1024 : {1'b0, head.len};
  assign exp_d   = (eff_len + 11'(DPB - 1)) / 11'(DPB);
  assign sc_d    = (status_d == 3'b000);
  assign dw0_d   = {(sc_d ? 3'b010 : 3'b000), 5'b01010, head.tag[9], 3'b000, head.tag[8],
                    9'd0, (sc_d ? head.len : 10'd0)};
  assign dw1_d   = {bus.cfg_completer_id, status_d, 1'b0, eff_len[9:0], 2'b00};
  assign dw2_d   = {head.reqid, head.tag[7:0], 1'b0, head.addr};

  // rresp to completion status: OKAY/EXOKAY -> SC, SLVERR -> CA, DECERR -> UR
  always_comb begin
    status_d = 3'b000;
    case (bus.rresp)
      2'b10:   status_d = 3'b100;
      2'b11:   status_d = 3'b001;
      default: status_d = 3'b000;
    endcase
  end

  // context storage; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) ctx_mem_q[wptr_q] <= '{tag: bus.req_tag, len: bus.req_len_dw,
                                     reqid: bus.req_requester_id, addr: bus.req_addr_lo};
  end

  // FIFO pointers, occupancy and dropped-push pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= bus.req_wren && !push;
      if (push) wptr_q <= (wptr_q == PW'(REQ_FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_q <= (rptr_q == PW'(REQ_FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // completion FSM: peek first beat, send header, then forward or drain the beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      status_q    <= '0;
      exp_q       <= '0;
      beat_q      <= '0;
      err_rid_q   <= 1'b0;
      err_rlast_q <= 1'b0;
    end else begin
      err_rid_q   <= 1'b0;
      err_rlast_q <= 1'b0;
      case (state_q)
        IDLE: if (!empty && bus.rvalid) begin
          hdr_q     <= {dw2_d, dw1_d, dw0_d};
          status_q  <= status_d;
          exp_q     <= exp_d;
          err_rid_q <= (bus.rid != head.tag);
          state_q   <= HDR;
        end
        HDR: if (bus.cpl_hdr_ready) state_q <= (status_q == 3'b000) ? DATA : DRAIN;
        DATA, DRAIN: if (r_hs) begin
          err_rlast_q <= (bus.rlast != last_beat);
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= IDLE;
          end else begin
            beat_q  <= beat_q + 11'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // DATA is a straight pass-through of R onto the payload stream
  assign bus.rready         = (state_q == DATA) ? bus.cpl_data_ready : (state_q == DRAIN);
  assign bus.cpl_data_valid = (state_q == DATA) && bus.rvalid;
  assign bus.cpl_data       = (state_q == DATA) ? bus.rdata : '0;
  assign bus.cpl_data_last  = (state_q == DATA) && last_beat;
  assign bus.cpl_hdr_valid  = (state_q == HDR);
  assign bus.cpl_hdr        = hdr_q;
  assign bus.req_full       = full;
  assign bus.err_ctx_ovf    = ovf_q;
  assign bus.err_rid        = err_rid_q;
  assign bus.err_rlast      = err_rlast_q;
endmodule

// File: tb/tb_r_cpl_fsm.sv
// Bench for r_cpl_fsm: directed vector table, corner sequences, randomized model check.
module tb_r_cpl_fsm;
  localparam int DW    = 256;
  localparam int DEPTH = 4;
  localparam int NR    = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r_cpl_fsm_if #(.DATA_WIDTH(DW)) bus();
  r_cpl_fsm #(.DATA_WIDTH(DW), .REQ_FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [9:0]  tag;
    logic [9:0]  len;
    logic [15:0] reqid;
    logic [6:0]  addr;
    logic [1:0]  resp;
    logic [95:0] hdr;
    int          beats;
  } vec_t;

  typedef struct {
    logic [9:0]  tag;
    logic [9:0]  len;
    logic [15:0] reqid;
    logic [6:0]  addr;
    logic [1:0]  resp;
  } req_t;

  int n_chk = 0;
  int n_pass = 0;
  vec_t tbl [6];
  req_t rq [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] pat(input int key, input int beat);
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = 32'(key * 65536 + beat * 16 + w) ^ 32'h5A5A_0000;
    return v;
  endfunction

  function automatic int beats_of(input logic [9:0] len);
    int l;
    l = (len == 10'd0) ? 1024 : int'(len);
    return (l + 7) / 8;
  endfunction

  // completion header from the header-format rules, using plain arithmetic
  function automatic logic [95:0] exp_hdr(input req_t r, input logic [15:0] cid);
    int l, st;
    logic [31:0] d0, d1, d2;
    l  = (r.len == 10'd0) ? 1024 : int'(r.len);
    st = (r.resp == 2'b10) ? 4 : (r.resp == 2'b11) ? 1 : 0;
    d0 = (st == 0) ? 32'h4A00_0000 + 32'(r.len) : 32'h0A00_0000;
    if (r.tag[9]) d0 = d0 + 32'h0080_0000;
    if (r.tag[8]) d0 = d0 + 32'h0008_0000;
    d1 = 32'(cid) * 65536 + 32'(st) * 8192 + 32'((l * 4) % 4096);
    d2 = 32'(r.reqid) * 65536 + 32'(r.tag[7:0]) * 256 + 32'(r.addr);
    return {d2, d1, d0};
  endfunction

  task automatic push(input vec_t v);
    @(negedge clk);
    bus.req_wren = 1'b1; bus.req_tag = v.tag; bus.req_len_dw = v.len;
    bus.req_requester_id = v.reqid; bus.req_addr_lo = v.addr;
    @(negedge clk);
    bus.req_wren = 1'b0;
  endtask

  // feed one TLP's R beats and observe both completion streams
  task automatic serve(input logic [9:0] tag, input int key, input int nb, input logic [1:0] resp,
                       input bit toggle, input bit bad_rid, input int bad_last,
                       output logic [95:0] hdr, output int dbeats, output int nlast, output int lastpos,
                       output int nerr_rid, output int nerr_rlast, output int perr);
    int beat, rb, cyc;
    bit got_hdr;
    beat = 0; rb = 0; cyc = 0; got_hdr = 1'b0;
    hdr = '0; dbeats = 0; nlast = 0; lastpos = -1; nerr_rid = 0; nerr_rlast = 0; perr = 0;
    while (rb < nb && cyc < 3000) begin
      @(negedge clk);
      bus.rvalid = 1'b1; bus.rdata = pat(key, beat); bus.rresp = resp;
      bus.rid = bad_rid ? (tag ^ 10'h001) : tag;
      bus.rlast = ((beat == bad_last) != (beat == nb - 1));
      bus.cpl_hdr_ready = 1'b1;
      bus.cpl_data_ready = toggle ? (cyc[0] == 1'b0) : 1'b1;
      #4;
      if (bus.err_rid) nerr_rid++;
      if (bus.err_rlast) nerr_rlast++;
      if (!got_hdr) begin
        if (bus.rready || bus.cpl_data_valid) perr++;
        if (bus.cpl_hdr_valid) begin hdr = bus.cpl_hdr; got_hdr = 1'b1; end
      end else begin
        if (resp[1]) begin
          if (!bus.rready || bus.cpl_data_valid) perr++;
        end else begin
          if (bus.rready !== bus.cpl_data_ready || !bus.cpl_data_valid) perr++;
          if (bus.cpl_data !== pat(key, beat)) perr++;
        end
        if (bus.rready) begin
          if (bus.cpl_data_valid) begin
            dbeats++;
            if (bus.cpl_data_last) begin nlast++; lastpos = beat; end
          end
          beat++; rb++;
        end
      end
      cyc++;
    end
    if (rb < nb) perr++;
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.cpl_data_ready = 1'b0; bus.cpl_hdr_ready = 1'b0;
    repeat (3) begin
      #4;
      if (bus.err_rid) nerr_rid++;
      if (bus.err_rlast) nerr_rlast++;
      if (bus.rready || bus.cpl_hdr_valid || bus.cpl_data_valid) perr++;
      @(negedge clk);
    end
  endtask

  // rvalid with nothing queued must not start a completion
  task automatic idle_check(input string nm);
    int seen;
    seen = 0;
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rresp = 2'b00; bus.rid = 10'd0;
    repeat (3) begin
      #4;
      if (bus.cpl_hdr_valid || bus.rready) seen++;
      @(negedge clk);
    end
    bus.rvalid = 1'b0;
    chk(nm, 256'(seen), 256'd0);
  endtask

  task automatic run_vec(input string nm, input vec_t v, input int key, input bit toggle);
    logic [95:0] h;
    int db, nl, lp, er, el, pe, xb;
    xb = v.resp[1] ? 0 : v.beats;
    serve(v.tag, key, v.beats, v.resp, toggle, 1'b0, -1, h, db, nl, lp, er, el, pe);
    chk({nm, "_hdr"}, 256'(h), 256'(v.hdr));
    chk({nm, "_dbeats"}, 256'(db), 256'(xb));
    chk({nm, "_nlast"}, 256'(nl), 256'(v.resp[1] ? 0 : 1));
    chk({nm, "_lastpos"}, 256'(lp), 256'(v.resp[1] ? -1 : v.beats - 1));
    chk({nm, "_proto"}, 256'(pe), 256'd0);
    chk({nm, "_errs"}, 256'(er + el), 256'd0);
  endtask

  initial begin
    logic [95:0] h;
    int db, nl, lp, er, el, pe, cnt;
    logic [4:0] full_seen, ovf_seen;
    logic [15:0] cid;
    int p_idx, r_idx, r_beat, m_idx, m_beat, bad, cyc, nb;
    bit rv, m_hdr;

    tbl[0] = '{10'h005, 10'd1,  16'hABCD, 7'h04, 2'b00, 96'hABCD0504_01000004_4A000001, 1};
    tbl[1] = '{10'h3FF, 10'd9,  16'h1234, 7'h7F, 2'b01, 96'h1234FF7F_01000024_4A880009, 2};
    tbl[2] = '{10'h100, 10'd0,  16'h0001, 7'h00, 2'b00, 96'h00010000_01000000_4A080000, 128};
    tbl[3] = '{10'h200, 10'd4,  16'hBEEF, 7'h10, 2'b10, 96'hBEEF0010_01008010_0A800000, 1};
    tbl[4] = '{10'h0AA, 10'd16, 16'h5555, 7'h3C, 2'b11, 96'h5555AA3C_01002040_0A000000, 2};
    tbl[5] = '{10'h001, 10'd17, 16'h0F0F, 7'h01, 2'b00, 96'h0F0F0101_01000044_4A000011, 3};

    bus.req_wren = 1'b0; bus.req_tag = '0; bus.req_len_dw = '0; bus.req_requester_id = '0;
    bus.req_addr_lo = '0; bus.cfg_completer_id = 16'h0100;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rid = '0;
    bus.cpl_hdr_ready = 1'b0; bus.cpl_data_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", 256'({bus.req_full, bus.rready, bus.cpl_hdr_valid, bus.cpl_data_valid,
                          bus.cpl_data_last, bus.err_ctx_ovf, bus.err_rid, bus.err_rlast}), 256'd0);
    chk("rst_hdr", 256'(bus.cpl_hdr), 256'd0);
    rst_n = 1'b1;
    idle_check("empty_rvalid");

    // directed table
    for (int i = 0; i < 6; i++) begin
      push(tbl[i]);
      run_vec($sformatf("vec%0d", i), tbl[i], i, i == 1);
      idle_check($sformatf("vec%0d_empty", i));
    end

    // five pushes into a depth-4 FIFO with no R traffic
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_wren = 1'b1; bus.req_tag = tbl[i].tag; bus.req_len_dw = tbl[i].len;
      bus.req_requester_id = tbl[i].reqid; bus.req_addr_lo = tbl[i].addr;
      #4;
      full_seen[i] = bus.req_full; ovf_seen[i] = bus.err_ctx_ovf;
    end
    @(negedge clk);
    bus.req_wren = 1'b0;
    #4;
    chk("ovf_full_hist", 256'(full_seen), 256'(5'b10000));
    chk("ovf_none_early", 256'(ovf_seen), 256'd0);
    chk("ovf_pulse", 256'(bus.err_ctx_ovf), 256'd1);
    @(negedge clk);
    #4;
    chk("ovf_one_cycle", 256'(bus.err_ctx_ovf), 256'd0);
    chk("ovf_still_full", 256'(bus.req_full), 256'd1);

    // header must hold while cpl_hdr_ready is low
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rdata = pat(0, 0); bus.rresp = tbl[0].resp; bus.rid = tbl[0].tag;
    bus.rlast = 1'b1; bus.cpl_hdr_ready = 1'b0;
    cnt = 0;
    repeat (5) begin
      #4;
      if (bus.cpl_hdr_valid && bus.cpl_hdr === tbl[0].hdr && !bus.rready) cnt++;
      @(negedge clk);
    end
    chk("hdr_stall_hold", 256'(cnt), 256'd4);
    for (int i = 0; i < 4; i++) run_vec($sformatf("order%0d", i), tbl[i], i, 1'b0);
    #4;
    chk("order_not_full", 256'(bus.req_full), 256'd0);
    idle_check("order_empty");

    // rid mismatch and early rlast: both flagged, TLP still runs 2 beats
    push('{10'h0AB, 10'd9, 16'h7777, 7'h22, 2'b00, 96'd0, 2});
    serve(10'h0AB, 50, 2, 2'b00, 1'b0, 1'b1, 0, h, db, nl, lp, er, el, pe);
    chk("rid_err_pulse", 256'(er), 256'd1);
    chk("rlast_err_pulse", 256'(el), 256'd1);
    chk("rid_dbeats", 256'(db), 256'd2);
    chk("rid_lastpos", 256'(lp), 256'd1);
    chk("rid_proto", 256'(pe), 256'd0);

    // reset in the middle of a TLP flushes everything
    push(tbl[1]);
    bus.rvalid = 1'b1; bus.rdata = pat(1, 0); bus.rresp = 2'b00; bus.rid = tbl[1].tag;
    bus.rlast = 1'b0; bus.cpl_hdr_ready = 1'b1; bus.cpl_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.rdata = pat(1, 1); bus.rlast = 1'b1;
    #1;
    chk("mid_tlp_active", 256'(bus.cpl_data_valid), 256'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 256'({bus.req_full, bus.rready, bus.cpl_hdr_valid, bus.cpl_data_valid}), 256'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.rlast = 1'b0;
    cnt = 0;
    repeat (3) begin
      #4;
      if (bus.cpl_hdr_valid || bus.rready) cnt++;
      @(negedge clk);
    end
    bus.rvalid = 1'b0; bus.cpl_hdr_ready = 1'b0; bus.cpl_data_ready = 1'b0;
    chk("mid_rst_flushed", 256'(cnt), 256'd0);
    push(tbl[0]);
    run_vec("post_rst", tbl[0], 0, 1'b0);

    // randomized traffic against the request-queue model
    cid = 16'($urandom);
    bus.cfg_completer_id = cid;
    for (int i = 0; i < NR; i++) begin
      req_t r;
      r.tag = 10'($urandom); r.reqid = 16'($urandom); r.addr = 7'($urandom);
      r.len = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
      r.resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      rq.push_back(r);
    end
    p_idx = 0; r_idx = 0; r_beat = 0; m_idx = 0; m_beat = 0; bad = 0; cyc = 0;
    rv = 1'b0; m_hdr = 1'b0;
    while (m_idx < NR && cyc < 20000) begin
      @(negedge clk);
      bus.req_wren = 1'b0;
      if (p_idx < NR && !bus.req_full && $urandom_range(0, 2) != 0) begin
        bus.req_wren = 1'b1; bus.req_tag = rq[p_idx].tag; bus.req_len_dw = rq[p_idx].len;
        bus.req_requester_id = rq[p_idx].reqid; bus.req_addr_lo = rq[p_idx].addr;
      end
      if (!rv && r_idx < p_idx && $urandom_range(0, 3) != 0) rv = 1'b1;
      bus.rvalid = rv;
      if (r_idx < p_idx) begin
        nb = beats_of(rq[r_idx].len);
        bus.rdata = pat(1000 + r_idx, r_beat); bus.rresp = rq[r_idx].resp;
        bus.rid = rq[r_idx].tag; bus.rlast = (r_beat == nb - 1);
      end
      bus.cpl_hdr_ready = ($urandom_range(0, 3) != 0);
      bus.cpl_data_ready = ($urandom_range(0, 3) != 0);
      #4;
      if (bus.err_rid || bus.err_rlast || bus.err_ctx_ovf) bad++;
      if (bus.cpl_hdr_valid && bus.cpl_hdr_ready) begin
        if (m_idx >= p_idx || m_hdr) bad++;
        else begin
          chk("rand_hdr", 256'(bus.cpl_hdr), 256'(exp_hdr(rq[m_idx], cid)));
          if (rq[m_idx].resp[1]) m_idx++;
          else m_hdr = 1'b1;
        end
      end
      if (bus.cpl_data_valid && bus.cpl_data_ready) begin
        if (!m_hdr) bad++;
        else begin
          nb = beats_of(rq[m_idx].len);
          chk("rand_data", bus.cpl_data, pat(1000 + m_idx, m_beat));
          chk("rand_last", 256'(bus.cpl_data_last), 256'(m_beat == nb - 1));
          m_beat++;
          if (m_beat == nb) begin m_idx++; m_beat = 0; m_hdr = 1'b0; end
        end
      end
      if (rv && bus.rready) begin
        r_beat++; rv = 1'b0;
        if (r_beat == beats_of(rq[r_idx].len)) begin r_idx++; r_beat = 0; end
      end
      if (bus.req_wren) p_idx++;
      cyc++;
    end
    @(negedge clk);
    bus.req_wren = 1'b0; bus.rvalid = 1'b0; bus.cpl_hdr_ready = 1'b0; bus.cpl_data_ready = 1'b0;
    chk("rand_cpl_done", 256'(m_idx), 256'(NR));
    chk("rand_r_done", 256'(r_idx), 256'(NR));
    chk("rand_proto", 256'(bad), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
